deco_read: RTL and testbench
============================

Name: deco_read

Overview:
- Read-side counterpart of the store write-enable decoder: it decodes load addresses from the ALU and returns read data from RAM, switches, UART or the Gauss unit.
- Registered response path with a small FSM. It stalls the core while synchronous RAM latency elapses.
- Issues a read-to-clear acknowledge to the UART when its RX data register is read.
- Sits between the core's load path and the peripheral/RAM read ports.

Parameters:
- DW, 32, data/address width.
- RAM_LAT, 1, RAM read latency in cycles, ≥1.
- SW_W, 16, switch input width.
- SYNC_STAGES, 2, switch synchronizer depth, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- re_i  in  1  load request from main control
- addr_i  in  DW  load address from ALU
- rd_data_o  out  DW  returned load data
- rd_valid_o  out  1  one-cycle pulse; rd_data_o valid
- stall_o  out  1  hold PC/pipeline while a load is outstanding
- ram_rdata_i  in  DW  RAM read data
- re_Mem_o  out  1  RAM read enable
- switches_i  in  SW_W  asynchronous board switches
- uart_rdata_i  in  DW  UART register read data
- uart_rx_ack_o  out  1  pulse: RX data register consumed
- gauss_rdata_i  in  DW  Gauss unit result

Behaviour:
- Reset is asynchronous, active-low, single clock. rst_n low forces state IDLE, rd_data_o=0, rd_valid_o=0, re_Mem_o=0, uart_rx_ack_o=0, synchronizer flops=0, and the latched address/select=0.
- Address map, decoded from latched addr bits:
  - [15:12]=0001 → RAM.
  - [15:12]=0010 & [7:0]=0x00 → switches, zero-extended.
  - [15:12]=0010 & [7:4]=0001 → UART. [3:0]=0x0 is control/status; 0x8 is RX data.
  - [15:12]=0010 & [7:4]=0011 → Gauss.
  - Anything else → unmapped, returns 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on re_i=1, latch addr_i and select.
    - RAM target: assert re_Mem_o for the acceptance cycle only, load counter with RAM_LAT-1, go to WAIT.
    - Non-RAM target: capture source data into rd_data_o and go to RESP.
  - WAIT: decrement counter. At 0, capture ram_rdata_i and go to RESP.
  - RESP: rd_valid_o=1 for exactly one cycle, then return to IDLE unconditionally. A new re_i is accepted only in IDLE, never back-to-back from RESP.
- stall_o is combinational: (IDLE & re_i) | WAIT. It is low in RESP, so the core advances in the same cycle it sees rd_valid_o.
- Latency from acceptance to rd_valid_o:
  - Peripheral or unmapped: 1 cycle.
  - RAM: RAM_LAT+1 cycles.
- The requester holds re_i and addr_i while stall_o=1. Changes to addr_i after acceptance are ignored.
- uart_rx_ack_o pulses 1 cycle, coincident with rd_valid_o, only for a UART RX data read (offset 0x8). Status reads never ack.
- Switches pass through a SYNC_STAGES-flop synchronizer. The value returned is the synchronizer output sampled at acceptance.
- rd_data_o holds its last value outside RESP. Consumers qualify it with rd_valid_o.
- If rst_n is asserted mid-WAIT: return immediately to IDLE, emit no rd_valid_o and no ack.
- re_i during WAIT is ignored: there is no queueing and no second accept.

Optional Feature:
- Macro: DECO_READ_ERR_EN.
- When defined, two extra outputs are added:
  - err_o: sticky; set in RESP of an unmapped read, cleared only by reset.
  - err_addr_o[DW-1:0]: captures the address of the first unmapped read.
  - Both reset to 0.
- When undefined, those ports and their logic are absent, and unmapped reads silently return 0.

Decomposition:
- Package deco_pkg holds:
  - region typedef enum {REG_NONE, REG_RAM, REG_SW, REG_UART, REG_GAUSS};
  - FSM state enum;
  - address-field constants (RAM_PAGE=4'h1, IO_PAGE=4'h2, UART_BLK=4'h1, GAUSS_BLK=4'h3, UART_RXDATA_OFS=4'h8).
- Sub-module: sync_nff, a generic N-stage synchronizer used for the switches.

Test Plan:
- Reset held, then released: all outputs 0, state IDLE; stall_o=0 with re_i=0.
- RAM_LAT=1, read 0x1004 with ram_rdata_i=0xDEADBEEF:
  - re_Mem_o pulses in cycle 0 and stall_o is high in cycles 0–1.
  - rd_valid_o in cycle 2 with rd_data_o=0xDEADBEEF.
- switches_i=0xA5A5 stable ≥3 cycles, read 0x2000: rd_valid_o 1 cycle after accept, rd_data_o=0x0000A5A5, stall_o low at valid.
- UART reads:
  - Read 0x2018 with uart_rdata_i=0x41: rd_data_o=0x41 and uart_rx_ack_o pulses once with rd_valid_o.
  - Read 0x2010: no ack.
- Unmapped read 0x3000: rd_data_o=0, rd_valid_o after 1 cycle. With DECO_READ_ERR_EN, err_o=1 and err_addr_o=0x3000; both remain set after a following valid RAM read.
- RAM_LAT=3, read 0x1000, pulse rst_n low during WAIT: no rd_valid_o. A fresh read of 0x2030 (gauss_rdata_i=0x1234) returns 0x1234 normally.

Source files
------------

// File: rtl/deco_read_pkg.sv
// deco_pkg: shared types and address-map constants for the load-side decoder.
// Regions are decoded from addr[15:12] (page), addr[7:4] (block) and addr[3:0] (offset).
package deco_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_SW,
    REG_UART,
    REG_GAUSS
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] RAM_PAGE        = 4'h1;
  localparam logic [3:0] IO_PAGE         = 4'h2;
  localparam logic [3:0] UART_BLK        = 4'h1;
  localparam logic [3:0] GAUSS_BLK       = 4'h3;
  localparam logic [3:0] UART_RXDATA_OFS = 4'h8;

  // Map the low 16 address bits onto a read region; anything unrecognised is REG_NONE.
  function automatic region_e decode_region(input logic [15:0] a);
    region_e r;
    r = REG_NONE;
    if (a[15:12] == RAM_PAGE) begin
      r = REG_RAM;
    end else if (a[15:12] == IO_PAGE) begin
      if (a[7:0] == 8'h00) begin
        r = REG_SW;
      end else if (a[7:4] == UART_BLK) begin
        r = REG_UART;
      end else if (a[7:4] == GAUSS_BLK) begin
        r = REG_GAUSS;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/deco_read_sync_nff.sv
// sync_nff: generic N-stage flop synchronizer for bringing asynchronous inputs
// into the clk domain. STAGES must be at least 2.
module sync_nff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] stage;

  // Shift the raw input through the flop chain; the oldest stage is the safe output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/deco_read.sv
// deco_read: load-side address decoder returning RAM, switch, UART or Gauss data.
// A request is accepted in IDLE only; RAM reads wait RAM_LAT cycles in WAIT, then
// every read presents one RESP cycle with rd_valid_o high.
// Optional feature macro: DECO_READ_ERR_EN adds sticky err_o / err_addr_o that
// record the first unmapped read.
module deco_read
  import deco_pkg::*;
#(
  parameter int DW          = 32,
  parameter int RAM_LAT     = 1,
  parameter int SW_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re_i,
  input  logic [DW-1:0] addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          stall_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          re_Mem_o,
  input  logic [SW_W-1:0] switches_i,
  input  logic [DW-1:0] uart_rdata_i,
  output logic          uart_rx_ack_o,
  input  logic [DW-1:0] gauss_rdata_i
`ifdef DECO_READ_ERR_EN
  ,
  output logic          err_o,
  output logic [DW-1:0] err_addr_o
`endif
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e          state_q, state_d;
  region_e         sel_in, sel_q;
  logic [DW-1:0]   addr_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   src_data;
  logic [SW_W-1:0] sw_sync;
  logic            accept;

  sync_nff #(
    .W      (SW_W),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switches_i),
    .q     (sw_sync)
  );

  assign sel_in = decode_region(addr_i[15:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept only in IDLE, RAM goes through WAIT, RESP always lasts one cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (re_i) begin
          accept  = 1'b1;
          state_d = (sel_in == REG_RAM) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the non-RAM source for the address being accepted; unmapped returns zero.
  always_comb begin
    src_data = '0;
    case (sel_in)
      REG_SW:    src_data = DW'(sw_sync);
      REG_UART:  src_data = uart_rdata_i;
      REG_GAUSS: src_data = gauss_rdata_i;
      default:   src_data = '0;
    endcase
  end

  // Latch the request at acceptance, count down RAM latency, and capture the response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      sel_q     <= REG_NONE;
      cnt_q     <= '0;
      rd_data_o <= '0;
    end else if (accept) begin
      addr_q <= addr_i;
      sel_q  <= sel_in;
      cnt_q  <= CW'(RAM_LAT - 1);
      if (sel_in != REG_RAM) begin
        rd_data_o <= src_data;
      end
    end else if (state_q == WAIT) begin
      if (cnt_q == '0) begin
        rd_data_o <= ram_rdata_i;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign rd_valid_o    = (state_q == RESP);
  assign stall_o       = ((state_q == IDLE) && re_i) || (state_q == WAIT);
  assign re_Mem_o      = rst_n && accept && (sel_in == REG_RAM);
  assign uart_rx_ack_o = (state_q == RESP) && (sel_q == REG_UART) &&
                         (addr_q[3:0] == UART_RXDATA_OFS);

`ifdef DECO_READ_ERR_EN
  // Record the first unmapped read; the flag stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if ((state_q == RESP) && (sel_q == REG_NONE) && !err_o) begin
      err_o      <= 1'b1;
      err_addr_o <= addr_q;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[DW-1:16];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[DW-1:16], addr_q[DW-1:4]};
`endif

endmodule

// File: tb/tb_deco_read.sv
// tb_deco_read: scoreboard bench for deco_read. Expected responses are queued when a
// load is driven and checked when rd_valid_o appears, including the arrival cycle.
// Build with +define+DECO_READ_ERR_EN to also check err_o / err_addr_o.
`timescale 1ns/1ps
module tb_deco_read;

  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SW_W = 16;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            re_i;
  logic [DW-1:0]   addr_i;
  logic [DW-1:0]   rd_data_o;
  logic            rd_valid_o;
  logic            stall_o;
  logic [DW-1:0]   ram_rdata_i;
  logic            re_Mem_o;
  logic [SW_W-1:0] switches_i;
  logic [DW-1:0]   uart_rdata_i;
  logic            uart_rx_ack_o;
  logic [DW-1:0]   gauss_rdata_i;
`ifdef DECO_READ_ERR_EN
  logic            err_o;
  logic [DW-1:0]   err_addr_o;
`endif

  deco_read #(
    .DW          (DW),
    .RAM_LAT     (LAT),
    .SW_W        (SW_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .re_i          (re_i),
    .addr_i        (addr_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .stall_o       (stall_o),
    .ram_rdata_i   (ram_rdata_i),
    .re_Mem_o      (re_Mem_o),
    .switches_i    (switches_i),
    .uart_rdata_i  (uart_rdata_i),
    .uart_rx_ack_o (uart_rx_ack_o),
    .gauss_rdata_i (gauss_rdata_i)
`ifdef DECO_READ_ERR_EN
    ,
    .err_o         (err_o),
    .err_addr_o    (err_addr_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        ack;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: every valid must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (rd_valid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rd_data", rd_data_o, e.data);
          checkOutput("rx_ack", {31'd0, uart_rx_ack_o}, {31'd0, e.ack});
          checkOutput("valid_cycle", cyc, e.cyc);
          checkOutput("stall_at_valid", {31'd0, stall_o}, 32'd0);
        end
      end else begin
        checkOutput("ack_without_valid", {31'd0, uart_rx_ack_o}, 32'd0);
      end
    end
  end

  // Drive one load, hold it while stalled, and check stall/re_Mem_o cycle by cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_data,
                               input logic exp_ack, input bit is_ram);
    int lat;
    lat = is_ram ? LAT + 1 : 1;
    @(negedge clk);
    re_i   = 1'b1;
    addr_i = addr;
    sb.push_back('{exp_data, exp_ack, cyc + lat});
    #1;
    checkOutput("stall_at_accept", {31'd0, stall_o}, 32'd1);
    checkOutput("re_mem_at_accept", {31'd0, re_Mem_o}, {31'd0, is_ram});
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      addr_i = addr ^ 32'h0000_F0FF;
      #1;
      checkOutput("stall_hold", {31'd0, stall_o}, (c < lat) ? 32'd1 : 32'd0);
      checkOutput("re_mem_hold", {31'd0, re_Mem_o}, 32'd0);
      if (c == lat) re_i = 1'b0;
    end
    @(negedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 32'd0);
    checkOutput("data_hold", rd_data_o, exp_data);
    checkOutput("idle_no_stall", {31'd0, stall_o}, 32'd0);
  endtask

  // Check every output at its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd_data"}, rd_data_o, 32'd0);
    checkOutput({tag, "_rd_valid"}, {31'd0, rd_valid_o}, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    checkOutput({tag, "_re_mem"}, {31'd0, re_Mem_o}, 32'd0);
    checkOutput({tag, "_ack"}, {31'd0, uart_rx_ack_o}, 32'd0);
`ifdef DECO_READ_ERR_EN
    checkOutput({tag, "_err"}, {31'd0, err_o}, 32'd0);
    checkOutput({tag, "_err_addr"}, err_addr_o, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    re_i          = 1'b0;
    addr_i        = '0;
    ram_rdata_i   = 32'hDEAD_BEEF;
    switches_i    = 16'hA5A5;
    uart_rdata_i  = 32'h0000_0041;
    gauss_rdata_i = 32'h0000_1234;

    repeat (3) @(negedge clk);
    #1;
    checkResetState("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkResetState("after_reset");

    applyStimulus(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus(32'h0000_2000, 32'h0000_A5A5, 1'b0, 1'b0);
    applyStimulus(32'h0000_2018, 32'h0000_0041, 1'b1, 1'b0);
    applyStimulus(32'h0000_2010, 32'h0000_0041, 1'b0, 1'b0);
    applyStimulus(32'h0000_2030, 32'h0000_1234, 1'b0, 1'b0);

    applyStimulus(32'h0000_3000, 32'h0000_0000, 1'b0, 1'b0);
`ifdef DECO_READ_ERR_EN
    checkOutput("err_set", {31'd0, err_o}, 32'd1);
    checkOutput("err_addr", err_addr_o, 32'h0000_3000);
`endif
    applyStimulus(32'h0000_2001, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(32'h0000_2020, 32'h0000_0000, 1'b0, 1'b0);

    ram_rdata_i = 32'h0BAD_F00D;
    applyStimulus(32'hABCD_1FFC, 32'h0BAD_F00D, 1'b0, 1'b1);
`ifdef DECO_READ_ERR_EN
    checkOutput("err_sticky", {31'd0, err_o}, 32'd1);
    checkOutput("err_addr_sticky", err_addr_o, 32'h0000_3000);
`endif

    switches_i = 16'h5A5A;
    repeat (SYNC + 1) @(negedge clk);
    applyStimulus(32'h0000_2000, 32'h0000_5A5A, 1'b0, 1'b0);

    uart_rdata_i = 32'h0000_007E;
    applyStimulus(32'hFFFF_2018, 32'h0000_007E, 1'b1, 1'b0);

    // Reset pulse while a RAM read sits in WAIT: no response may follow.
    @(negedge clk);
    re_i   = 1'b1;
    addr_i = 32'h0000_1000;
    @(negedge clk);
    #1;
    checkOutput("wait_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    re_i  = 1'b0;
    #1;
    checkResetState("mid_wait_reset");
    #1;
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    #1;
    checkOutput("no_valid_after_reset", sb.size(), 32'd0);
    checkOutput("idle_after_reset", {31'd0, stall_o}, 32'd0);

    applyStimulus(32'h0000_2030, 32'h0000_1234, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
